fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Write-side scheduler for the async FIFO. Shares the single FIFO write port (w_en/w_data, gated by w_full) among NUM_REQ requesters using round-robin arbitration with burst locking.
- Lives entirely in the FIFO write-clock domain. Drives the FIFO's w_en and w_data directly.
- Grants are held for up to MAX_BURST beats, so consecutive words from one requester stay contiguous in the FIFO.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_SIZE, 8, word width; matches the FIFO DATA_SIZE.
- MAX_BURST, 4, maximum accepted beats per grant (1..16).

Ports:
- clk  input  1  write-domain clock; the same clock as the FIFO w_clk.
- rst  input  1  synchronous, active-low reset; sampled on the rising clk edge.
- req_valid  input  NUM_REQ  per-requester word-valid.
- req_data  input  NUM_REQ*DATA_SIZE  per-requester word; requester i occupies bits [i*DATA_SIZE +: DATA_SIZE].
- req_ready  output  NUM_REQ  per-requester accept strobe; a beat transfers when valid and ready are both high.
- gnt  output  NUM_REQ  one-hot current owner; all zeros when idle.
- w_full  input  1  FIFO full flag.
- w_en  output  1  FIFO write enable.
- w_data  output  DATA_SIZE  FIFO write data.
- busy  output  1  high while in the BURST state.

Behaviour:
- State machine has two states: IDLE and BURST.
- Registered state:
  - owner index.
  - gnt (registered).
  - beat counter, width clog2(MAX_BURST)+1.
  - round-robin pointer rr_ptr.
- Reset (rst=0 at a clk edge) sets:
  - state=IDLE, gnt=0, beat=0, rr_ptr=0.
  - Outputs: w_en=0, req_ready=0, w_data=0, busy=0.
  - Reset asserted mid-burst abandons the burst at that edge. No write occurs in the reset cycle.
- IDLE:
  - If any req_valid is high, select the first requester with valid high, searching from rr_ptr upward and wrapping modulo NUM_REQ.
  - At the next edge: owner=winner, gnt=onehot(winner), beat=0, state=BURST.
  - No write occurs in IDLE, so arbitration latency is 1 cycle.
  - If no requester is valid, remain in IDLE.
- BURST (combinational outputs):
  - wr = req_valid[owner] & ~w_full.
  - w_en = wr.
  - req_ready = gnt when wr is high, else 0.
  - w_data = req_data slice of owner, else 0 when wr is low.
  - busy = 1.
- Write beat: beat increments on every cycle with wr=1.
- Leaving BURST: at the next edge go to IDLE, with gnt=0 and rr_ptr=(owner+1) mod NUM_REQ, when either:
  - wr=1 and beat==MAX_BURST-1, which is the last permitted beat; or
  - req_valid[owner]=0, in which case the owner dropped and no write occurs that cycle.
- w_full=1 with owner valid:
  - Stall in BURST. The grant is held, beat is unchanged, w_en=0 and req_ready=0.
  - The stall is unbounded; no timeout.
- Non-owners always see req_ready=0. Their valid and data are ignored.
- A requester must hold valid and data stable until its ready is seen; this is a protocol rule on requesters.
- Back-to-back bursts:
  - There is always one IDLE cycle between bursts.
  - A single requester that stays valid receives at most MAX_BURST beats per MAX_BURST+1 cycles when other requesters are idle.
  - It loses to any other valid requester that is at or after rr_ptr.
- MAX_BURST=1 degenerates to per-word round-robin.
- The arbiter never asserts w_en while w_full=1. This is a required invariant.

Optional Feature:
- Macro: FIFO_WR_ARB_STATS_EN.
- Defined:
  - Adds output stall_cnt [15:0].
  - Increments on each BURST cycle with req_valid[owner]=1 and w_full=1.
  - Saturates at 16'hFFFF.
  - Reset value 0; cleared only by rst.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset: hold rst=0 for 3 cycles with all req_valid=1 -> gnt=0, w_en=0, req_ready=0, busy=0 throughout; first grant appears 1 cycle after rst=1, to requester 0.
- Single requester: req1 valid continuously with data 8'h10..8'h17, w_full=0, MAX_BURST=4 -> w_data sequence 10,11,12,13, then 1 idle cycle, then 14..17; w_en pattern 1111 0 1111.
- Round-robin: all four requesters valid continuously -> grant order 0,1,2,3,0; each burst is 4 beats; a gap of exactly 1 idle cycle between bursts.
- Full stall: during req2 beat 2, drive w_full=1 for 5 cycles -> w_en=0, req_ready=0, gnt stays 4'b0100; resumes with beat 3 data unchanged once w_full=0, and burst total stays 4 beats.
- Early drop: req3 valid for 2 beats then low -> 2 writes, IDLE the next cycle, rr_ptr=0; then req0 valid is granted.
- Stats (FIFO_WR_ARB_STATS_EN): the 5-cycle stall above -> stall_cnt=5; forcing 70000 stall cycles -> stall_cnt=16'hFFFF.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Handshake bundle between the write-side requesters, the arbiter and the FIFO write port.
interface fifo_wr_arbiter_if #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_SIZE = 8
);

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*DATA_SIZE-1:0] req_data;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ-1:0]           gnt;
  logic                         w_full;
  logic                         w_en;
  logic [DATA_SIZE-1:0]         w_data;
  logic                         busy;

  // Requester/FIFO side: drives words and the full flag, observes grants and writes.
  modport master (
    output req_valid, req_data, w_full,
    input  req_ready, gnt, w_en, w_data, busy
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_data, w_full,
    output req_ready, gnt, w_en, w_data, busy
  );

endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locking scheduler for the single async-FIFO write port.
// Optional macro FIFO_WR_ARB_STATS_EN adds a saturating full-stall counter output.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  fifo_wr_arbiter_if.slave bus
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  localparam int unsigned OWN_W  = $clog2(NUM_REQ);
  localparam int unsigned BEAT_W = $clog2(MAX_BURST) + 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [OWN_W-1:0]     r_owner;
  logic [OWN_W-1:0]     w_owner_nxt;
  logic [OWN_W-1:0]     r_rr_ptr;
  logic [OWN_W-1:0]     w_rr_nxt;
  logic [OWN_W-1:0]     w_owner_inc;
  logic [OWN_W-1:0]     w_win;
  logic                 w_any;
  logic [NUM_REQ-1:0]   r_gnt;
  logic [NUM_REQ-1:0]   w_gnt_nxt;
  logic [BEAT_W-1:0]    r_beat;
  logic [BEAT_W-1:0]    w_beat_nxt;
  logic                 w_own_valid;
  logic                 w_wr;
  logic [DATA_SIZE-1:0] w_words [NUM_REQ];

  // Index reached by stepping k places upward from base, wrapping at NUM_REQ.
  function automatic logic [OWN_W-1:0] rr_idx(input logic [OWN_W-1:0] base,
                                              input int unsigned      k);
    return OWN_W'((32'(base) + k) % NUM_REQ);
  endfunction

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_words[gi] = bus.req_data[gi*DATA_SIZE +: DATA_SIZE];
  end

  // First valid requester at or after the round-robin pointer.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!w_any && bus.req_valid[rr_idx(r_rr_ptr, k)]) begin
        w_any = 1'b1;
        w_win = rr_idx(r_rr_ptr, k);
      end
    end
  end

  assign w_owner_inc = (r_owner == OWN_W'(NUM_REQ - 1)) ? '0 : r_owner + OWN_W'(1);

  // Next-state and write qualification; reset suppresses any write in its cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_gnt_nxt   = r_gnt;
    w_beat_nxt  = r_beat;
    w_rr_nxt    = r_rr_ptr;
    w_own_valid = 1'b0;
    w_wr        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt = S_BURST;
          w_owner_nxt = w_win;
          w_gnt_nxt   = NUM_REQ'(1) << w_win;
          w_beat_nxt  = '0;
        end
      end
      S_BURST: begin
        w_own_valid = bus.req_valid[r_owner];
        w_wr        = w_own_valid & ~bus.w_full & rst;
        if (w_wr) begin
          w_beat_nxt = r_beat + BEAT_W'(1);
        end
        // Close on the last permitted beat, or immediately when the owner drops.
        if ((w_wr && (r_beat == BEAT_W'(MAX_BURST - 1))) || !w_own_valid) begin
          w_state_nxt = S_IDLE;
          w_gnt_nxt   = '0;
          w_rr_nxt    = w_owner_inc;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_owner  <= '0;
      r_gnt    <= '0;
      r_beat   <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_gnt    <= w_gnt_nxt;
      r_beat   <= w_beat_nxt;
      r_rr_ptr <= w_rr_nxt;
    end
  end

  assign bus.w_en      = w_wr;
  assign bus.req_ready = w_wr ? r_gnt : '0;
  assign bus.w_data    = w_wr ? w_words[r_owner] : '0;
  assign bus.gnt       = r_gnt;
  assign bus.busy      = (r_state == S_BURST);

`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0] r_stall_cnt;

  // Counts cycles the owner had a word ready but the FIFO was full.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if ((r_state == S_BURST) && w_own_valid && bus.w_full &&
                 (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus randomized traffic vs a cycle model.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_SIZE(DW)) bus ();

`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0] stall_cnt;
`endif

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_SIZE(DW), .MAX_BURST(MB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Requester sources: words remaining, current word, presenting flag.
  int          src_cnt  [N];
  logic [DW-1:0] src_word [N];
  bit          src_on   [N];
  bit          rand_src;

  // Reference model: whether a grant is active, its owner, beats written, next search start.
  bit m_act;
  int m_owner;
  int m_beat;
  int m_ptr;
  int m_stall;

  logic [17:0]   exp_v, act_v;
  logic [N-1:0]  act_gnt, act_ready;
  logic          act_en, act_busy;
  logic [DW-1:0] act_data;
  logic [DW-1:0] wr_log [$];

  function automatic void clear_sources();
    for (int i = 0; i < N; i++) begin
      src_cnt[i]  = 0;
      src_word[i] = '0;
      src_on[i]   = 1'b1;
    end
    rand_src = 1'b0;
  endfunction

  // One clock: drive inputs, predict outputs, sample at negedge, advance model.
  task automatic tick(input bit rst_v, input bit full_v);
    logic [N-1:0]    v;
    logic [N*DW-1:0] d;
    logic [N-1:0]    eg;
    logic [N-1:0]    er;
    logic [DW-1:0]   ed;
    bit              ewr;
    int              win;
    for (int i = 0; i < N; i++) begin
      v[i]          = (src_cnt[i] > 0) && src_on[i];
      d[i*DW +: DW] = src_word[i];
    end
    rst           = rst_v;
    bus.req_valid = v;
    bus.req_data  = d;
    bus.w_full    = full_v;
    ewr   = rst_v && m_act && v[m_owner] && !full_v;
    eg    = m_act ? (N'(1) << m_owner) : '0;
    er    = ewr ? eg : '0;
    ed    = ewr ? src_word[m_owner] : '0;
    exp_v = {eg, er, ewr, ed, m_act};
    @(negedge clk);
    act_gnt   = bus.gnt;
    act_ready = bus.req_ready;
    act_en    = bus.w_en;
    act_data  = bus.w_data;
    act_busy  = bus.busy;
    act_v     = {act_gnt, act_ready, act_en, act_data, act_busy};
    if (act_en === 1'b1) wr_log.push_back(act_data);
    if (rst_v && m_act && v[m_owner] && full_v && m_stall < 65535) m_stall++;
    if (!rst_v) begin
      m_act = 1'b0; m_beat = 0; m_ptr = 0; m_stall = 0;
    end else if (!m_act) begin
      win = -1;
      for (int k = N - 1; k >= 0; k--) if (v[(m_ptr + k) % N]) win = (m_ptr + k) % N;
      if (win >= 0) begin
        m_act = 1'b1; m_owner = win; m_beat = 0;
      end
    end else if (ewr) begin
      m_beat++;
      if (m_beat == MB) begin
        m_act = 1'b0; m_ptr = (m_owner + 1) % N;
      end
    end else if (!v[m_owner]) begin
      m_act = 1'b0; m_ptr = (m_owner + 1) % N;
    end
    for (int i = 0; i < N; i++) begin
      if (er[i]) begin
        src_cnt[i]--;
        src_word[i]++;
      end
      if (rand_src && (er[i] || !src_on[i])) src_on[i] = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_sources();
    for (int i = 0; i < N; i++) src_cnt[i] = 100;
    for (int c = 0; c < 3; c++) begin
      tick(1'b0, 1'b0);
      checks++;
      if ({act_gnt, act_ready, act_en, act_busy} !== '0) begin
        failures++;
        $display("FAIL reset_outputs cycle %0d: got gnt=%b ready=%b en=%b busy=%b required all zero",
                 c, act_gnt, act_ready, act_en, act_busy);
      end
    end
    tick(1'b1, 1'b0);
    checks++;
    if (act_gnt !== 4'b0000) begin
      failures++;
      $display("FAIL reset_arb_cycle: got gnt=%b required 0000", act_gnt);
    end
    tick(1'b1, 1'b0);
    checks++;
    if (act_gnt !== 4'b0001 || act_en !== 1'b1) begin
      failures++;
      $display("FAIL reset_first_grant: got gnt=%b en=%b required gnt=0001 en=1", act_gnt, act_en);
    end
  endtask

  task automatic test_single();
    logic [11:0] en_seq;
    clear_sources();
    src_cnt[1]  = 8;
    src_word[1] = 8'h10;
    tick(1'b0, 1'b0);
    wr_log.delete();
    for (int c = 0; c < 12; c++) begin
      tick(1'b1, 1'b0);
      en_seq[11-c] = act_en;
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL single_cycle %0d: got %h required %h", c, act_v, exp_v);
      end
    end
    checks++;
    if (en_seq !== 12'b0111_1011_1100) begin
      failures++;
      $display("FAIL single_en_pattern: got %b required 011110111100", en_seq);
    end
    checks++;
    if (wr_log.size() != 8) begin
      failures++;
      $display("FAIL single_word_count: got %0d required 8", wr_log.size());
    end else begin
      for (int j = 0; j < 8; j++) begin
        checks++;
        if (wr_log[j] !== DW'(8'h10 + j)) begin
          failures++;
          $display("FAIL single_data %0d: got %h required %h", j, wr_log[j], 8'h10 + j);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [24:0]  en_seq, en_exp;
    logic [N-1:0] prev;
    logic [N-1:0] order [$];
    logic [N-1:0] want;
    clear_sources();
    for (int i = 0; i < N; i++) begin
      src_cnt[i]  = 100;
      src_word[i] = DW'(8'h40 + 16 * i);
    end
    tick(1'b0, 1'b0);
    prev = '0;
    for (int c = 0; c < 25; c++) begin
      tick(1'b1, 1'b0);
      en_seq[24-c] = act_en;
      en_exp[24-c] = (c % 5) != 0;
      if (act_gnt !== '0 && prev === '0) order.push_back(act_gnt);
      prev = act_gnt;
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL rr_cycle %0d: got %h required %h", c, act_v, exp_v);
      end
    end
    checks++;
    if (en_seq !== en_exp) begin
      failures++;
      $display("FAIL rr_en_pattern: got %b required %b", en_seq, en_exp);
    end
    checks++;
    if (order.size() != 5) begin
      failures++;
      $display("FAIL rr_grant_count: got %0d required 5", order.size());
    end else begin
      for (int j = 0; j < 5; j++) begin
        want = N'(1) << (j % N);
        checks++;
        if (order[j] !== want) begin
          failures++;
          $display("FAIL rr_order %0d: got %b required %b", j, order[j], want);
        end
      end
    end
  endtask

  task automatic test_full_stall();
    clear_sources();
    src_cnt[2]  = 4;
    src_word[2] = 8'h20;
    tick(1'b0, 1'b0);
    wr_log.delete();
    for (int c = 0; c < 3; c++) tick(1'b1, 1'b0);
    for (int c = 0; c < 5; c++) begin
      tick(1'b1, 1'b1);
      checks++;
      if (act_en !== 1'b0 || act_ready !== '0 || act_gnt !== 4'b0100 || act_busy !== 1'b1) begin
        failures++;
        $display("FAIL stall_hold %0d: got en=%b ready=%b gnt=%b busy=%b required en=0 ready=0 gnt=0100 busy=1",
                 c, act_en, act_ready, act_gnt, act_busy);
      end
    end
    tick(1'b1, 1'b0);
    checks++;
    if (act_en !== 1'b1 || act_data !== 8'h22) begin
      failures++;
      $display("FAIL stall_resume: got en=%b data=%h required en=1 data=22", act_en, act_data);
    end
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    checks++;
    if (act_busy !== 1'b0 || wr_log.size() != 4) begin
      failures++;
      $display("FAIL stall_burst_len: got busy=%b writes=%0d required busy=0 writes=4",
               act_busy, wr_log.size());
    end else if (wr_log[0] !== 8'h20 || wr_log[1] !== 8'h21 ||
                 wr_log[2] !== 8'h22 || wr_log[3] !== 8'h23) begin
      failures++;
      $display("FAIL stall_data: got %h %h %h %h required 20 21 22 23",
               wr_log[0], wr_log[1], wr_log[2], wr_log[3]);
    end
`ifdef FIFO_WR_ARB_STATS_EN
    checks++;
    if (stall_cnt !== 16'd5) begin
      failures++;
      $display("FAIL stall_cnt_5: got %0d required 5", stall_cnt);
    end
`endif
  endtask

  task automatic test_early_drop();
    clear_sources();
    src_cnt[3]  = 2;
    src_word[3] = 8'h30;
    tick(1'b0, 1'b0);
    wr_log.delete();
    for (int c = 0; c < 3; c++) tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    checks++;
    if (act_busy !== 1'b1 || act_en !== 1'b0 || act_gnt !== 4'b1000) begin
      failures++;
      $display("FAIL drop_cycle: got busy=%b en=%b gnt=%b required busy=1 en=0 gnt=1000",
               act_busy, act_en, act_gnt);
    end
    checks++;
    if (wr_log.size() != 2) begin
      failures++;
      $display("FAIL drop_writes: got %0d required 2", wr_log.size());
    end
    src_cnt[0] = 2;
    src_cnt[3] = 2;
    tick(1'b1, 1'b0);
    checks++;
    if (act_busy !== 1'b0 || act_gnt !== 4'b0000) begin
      failures++;
      $display("FAIL drop_idle: got busy=%b gnt=%b required busy=0 gnt=0000", act_busy, act_gnt);
    end
    tick(1'b1, 1'b0);
    checks++;
    if (act_gnt !== 4'b0001) begin
      failures++;
      $display("FAIL drop_rr_ptr: got gnt=%b required 0001", act_gnt);
    end
  endtask

  task automatic test_random();
    bit f, r;
    clear_sources();
    rand_src = 1'b1;
    for (int i = 0; i < N; i++) begin
      src_cnt[i]  = int'($urandom_range(5, 40));
      src_word[i] = DW'($urandom);
    end
    tick(1'b0, 1'b0);
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++)
        if (src_cnt[i] == 0 && $urandom_range(0, 9) == 0) src_cnt[i] = int'($urandom_range(1, 12));
      f = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 99) != 0);
      tick(r, f);
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL random_cycle %0d: got %h required %h", c, act_v, exp_v);
      end
      checks++;
      if (act_en === 1'b1 && f) begin
        failures++;
        $display("FAIL random_full_write %0d: got w_en=1 with w_full=1 required w_en=0", c);
      end
    end
`ifdef FIFO_WR_ARB_STATS_EN
    checks++;
    if (stall_cnt !== 16'(m_stall)) begin
      failures++;
      $display("FAIL random_stall_cnt: got %0d required %0d", stall_cnt, m_stall);
    end
`endif
  endtask

`ifdef FIFO_WR_ARB_STATS_EN
  task automatic test_stats_saturate();
    clear_sources();
    src_cnt[1] = 10;
    tick(1'b0, 1'b0);
    checks++;
    if (stall_cnt !== 16'd0) begin
      failures++;
      $display("FAIL stats_reset: got %0d required 0", stall_cnt);
    end
    tick(1'b1, 1'b0);
    for (int c = 0; c < 70000; c++) tick(1'b1, 1'b1);
    checks++;
    if (stall_cnt !== 16'hFFFF) begin
      failures++;
      $display("FAIL stats_saturate: got %h required ffff", stall_cnt);
    end
  endtask
`endif

  initial begin
    rst           = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.w_full    = 1'b0;
    clear_sources();
    m_act   = 1'b0;
    m_owner = 0;
    m_beat  = 0;
    m_ptr   = 0;
    m_stall = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_early_drop();
    test_random();
`ifdef FIFO_WR_ARB_STATS_EN
    test_stats_saturate();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
